// File: rtl/pipelined_barrel_shifter.sv
// Fully pipelined barrel shifter (LSL/LSR/ASR/ROL) with a valid/ready handshake.
// Stage k shifts by 2^k when bit k of the operand's shift amount is set.
module pipelined_barrel_shifter #(
    parameter  int WIDTH = 8,
    localparam int SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic [SHW-1:0]   in_shamt,
    input  logic [1:0]       in_mode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data
);

    typedef enum logic [1:0] {
        MODE_LSL = 2'b00,
        MODE_LSR = 2'b01,
        MODE_ASR = 2'b10,
        MODE_ROL = 2'b11
    } mode_t;

    // One enable for the whole pipeline: advance unless the held result is refused.
    logic adv;
    assign adv      = !out_valid || out_ready;
    assign in_ready = adv;

    genvar gi;
    generate
        for (gi = 0; gi < SHW; gi++) begin : gen_stage
            localparam int STEP = 1 << gi;
            // Stage gi only sees the shift-amount bits it and later stages still need.
            localparam int SW   = SHW - gi;

            logic             valid_in;
            logic [WIDTH-1:0] data_in;
            logic [SW-1:0]    shamt_in;
            mode_t            mode_in;
            logic             sign_in;
            logic [WIDTH-1:0] data_next;
            logic             valid_reg;
            logic [WIDTH-1:0] data_reg;

            if (gi == 0) begin : gen_src
                assign valid_in = in_valid;
                assign data_in  = in_data;
                assign shamt_in = in_shamt;
                assign mode_in  = mode_t'(in_mode);
                assign sign_in  = in_data[WIDTH-1];
            end else begin : gen_src
                assign valid_in = gen_stage[gi-1].valid_reg;
                assign data_in  = gen_stage[gi-1].data_reg;
                assign shamt_in = gen_stage[gi-1].gen_carry.shamt_reg;
                assign mode_in  = gen_stage[gi-1].gen_carry.mode_reg;
                assign sign_in  = gen_stage[gi-1].gen_carry.sign_reg;
            end

            always_comb begin
                data_next = data_in;
                if (shamt_in[0]) begin
                    case (mode_in)
                        MODE_LSL: data_next = data_in << STEP;
                        MODE_LSR: data_next = data_in >> STEP;
                        MODE_ASR: data_next = (data_in >> STEP) |
                                              ({WIDTH{sign_in}} & ~({WIDTH{1'b1}} >> STEP));
                        MODE_ROL: data_next = (data_in << STEP) | (data_in >> (WIDTH - STEP));
                        default:  data_next = data_in;
                    endcase
                end
            end

            always_ff @(posedge clk) begin
                if (rst) begin
                    valid_reg <= 1'b0;
                    data_reg  <= '0;
                end else if (adv) begin
                    valid_reg <= valid_in;
                    data_reg  <= data_next;
                end
            end

            // Control fields are dead after the final stage, so only carry them forward.
            if (gi < SHW - 1) begin : gen_carry
                logic [SW-2:0] shamt_reg;
                mode_t         mode_reg;
                logic          sign_reg;

                always_ff @(posedge clk) begin
                    if (rst) begin
                        shamt_reg <= '0;
                        mode_reg  <= MODE_LSL;
                        sign_reg  <= 1'b0;
                    end else if (adv) begin
                        shamt_reg <= shamt_in[SW-1:1];
                        mode_reg  <= mode_in;
                        sign_reg  <= sign_in;
                    end
                end
            end
        end
    endgenerate

    assign out_valid = gen_stage[SHW-1].valid_reg;
    assign out_data  = gen_stage[SHW-1].data_reg;

endmodule

// File: doc/pipelined_barrel_shifter.md
Name: pipelined_barrel_shifter

Overview:
Parametrised, fully pipelined barrel shifter. It supersedes the fixed 8-bit, left-shift-only combinational shifter. It supports four shift modes, any power-of-two data width, and a valid/ready handshake with backpressure. It sits between a producer and a consumer on one clock and accepts one operand per cycle when not stalled.

Parameters:
WIDTH, 8, data width in bits; power of two, >= 4.
SHW, $clog2(WIDTH), shift-amount width; derived localparam, not overridable.

Ports:
clk  input  1  system clock; all logic on rising edge.
rst  input  1  synchronous, active-high reset.
in_valid  input  1  producer presents an operand.
in_ready  output  1  block can accept an operand this cycle.
in_data  input  WIDTH  operand.
in_shamt  input  SHW  shift amount, 0..WIDTH-1.
in_mode  input  2  00 LSL, 01 LSR, 10 ASR, 11 ROL.
out_valid  output  1  result valid.
out_ready  input  1  consumer accepts the result.
out_data  output  WIDTH  shifted result.

Behaviour:
- Structure: SHW registered stages. Stage k (k=0..SHW-1) conditionally shifts by 2^k per bit k of the carried shamt, then registers data, shamt, mode and valid.
- Latency: an operand accepted on edge N appears on out_data/out_valid after edge N+SHW. For WIDTH=8 this is 3 cycles.
- Throughput: 1 result per cycle while out_ready=1.
- Stall: global enable adv = !out_valid | out_ready. When adv=1, every stage advances and a bubble (valid=0) enters if in_valid=0. When adv=0, all stage registers hold.
- in_ready = adv. This is combinational from out_ready and the last-stage valid. in_ready does not depend on in_valid.
- Transfer rules: input transfers when in_valid & in_ready. Output transfers when out_valid & out_ready. out_data is stable while out_valid=1 and out_ready=0.
- Mode LSL: zero-fill from the LSB.
- Mode LSR: zero-fill from the MSB.
- Mode ASR: fill from the MSB with the original in_data[WIDTH-1]. The sign is captured at input and carried through the stages.
- Mode ROL: bits shifted out of the MSB re-enter at the LSB.
- Right shift and rotate are computed directly, not by bit reversal. An implementation may use reversal internally, provided latency is unchanged.
- shamt=0: out_data = in_data in every mode.
- Data and mode/shamt registers in bubble stages are don't-care. out_data must not change while out_valid=1 and stalled.
- Reset: on any edge with rst=1, all stage valid bits clear and out_data resets to 0. out_valid=0 from that edge onward. in_ready=1 in the cycle after reset.
- Reset mid-operation: in-flight operands are discarded and never appear on the output.
- Simultaneous output accept and new input: allowed in the same cycle at full rate; nothing is lost or duplicated.
- in_valid held with in_ready=0: the operand is not captured. The producer must hold it (standard valid/ready rules).

Test Plan:
- WIDTH=8, out_ready=1. Send in_data=8'hB3, shamt=3 in each mode on consecutive cycles. Required outputs, 3 cycles after each input: LSL 8'h98, LSR 8'h16, ASR 8'hF6, ROL 8'h9D, back-to-back with out_valid high for 4 consecutive cycles.
- shamt=0 and shamt=7 with in_data=8'h81:
  - shamt=0: all modes output 8'h81.
  - shamt=7: LSL 8'h80, LSR 8'h01, ASR 8'hFF, ROL 8'hC0.
- Backpressure: stream 4 operands (8'h01,02,04,08, LSL by 1) and drop out_ready for 2 cycles once the first result is valid. Required: out_data holds 8'h02 while stalled and in_ready=0. Outputs then deliver 8'h02,04,08,10 in order, with no loss and no duplicates.
- Bubble handling: alternate in_valid 1/0 with out_ready=1. out_valid must mirror the input pattern delayed by 3 cycles.
- Reset mid-operation: accept 2 operands, assert rst for 1 cycle. Required: out_valid=0 for at least 3 cycles afterwards and neither result is ever emitted. A new operand accepted after reset emerges correctly 3 cycles later.
- Parameter sweep: WIDTH=16 and WIDTH=32 with random operands in all modes, compared against a reference model. Required latency is 4 and 5 cycles respectively.
